// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-side blocks: FSM state encodings,
// completion error codes, common keyboard command bytes, the frame length and
// the frame-building helpers.
// -----------------------------------------------------------------------------
package ps2_pkg;

    // Transmitter FSM state encodings
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_INHIBIT    = 3'd1;
    localparam logic [2:0] ST_WAIT_FIRST = 3'd2;
    localparam logic [2:0] ST_SHIFT      = 3'd3;
    localparam logic [2:0] ST_ACK        = 3'd4;
    localparam logic [2:0] ST_RELEASE    = 3'd5;
    localparam logic [2:0] ST_FAIL       = 3'd6;

    // Completion codes reported alongside done
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_NACK     = 2'b01;
    localparam logic [1:0] ERR_START_TO = 2'b10;
    localparam logic [1:0] ERR_XFER_TO  = 2'b11;

    // Frequently used keyboard commands
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESEND  = 8'hFE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // Odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Bits the host shifts out after the start bit, LSB first: {stop, parity, data}
    function automatic logic [9:0] build_frame(input logic [7:0] data);
        return {1'b1, odd_parity(data), data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// -----------------------------------------------------------------------------
// ps2_line_sync
// Brings one raw PS/2 line into the clk domain with a 2-flop synchronizer and
// derives single-cycle rise/fall pulses from a third register.
// Ports:
//   clk, rst   system clock, asynchronous active-low reset
//   line_in    raw pin value
//   line_sync  synchronized level
//   rise/fall  one-cycle edge pulses (3 cycles after the pin changes)
// -----------------------------------------------------------------------------
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_sync,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain; resets to the idle-high line level so no edge fires at reset exit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= line_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign line_sync = sync_r;
    assign rise      = ~prev_r &  sync_r;
    assign fall      =  prev_r & ~sync_r;

endmodule

// File: rtl/ps2_transmitter.sv
// -----------------------------------------------------------------------------
// ps2_transmitter
// Host-to-device PS/2 command sender. Inhibits the bus, issues the start bit,
// shifts one byte (LSB first, odd parity, stop) on device clock falling edges,
// checks the device ACK and reports the outcome with a one-cycle done pulse.
// Ports:
//   clk, rst                 system clock, asynchronous active-low reset
//   tx_data/tx_valid/tx_ready command byte handshake (accepted only in IDLE)
//   ps2_clk_in/ps2_data_in   raw open-drain line levels
//   ps2_clk_oe/ps2_data_oe   1 = pull the line low
//   busy                     not IDLE
//   done/ack_ok/err_code     completion pulse with result (held until next done)
// Build option: PS2_TX_RETRY_EN - retry NACK/timeouts up to MAX_RETRIES times.
// -----------------------------------------------------------------------------
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES       = 5000,
    parameter int unsigned START_TIMEOUT_CYCLES = 750000,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000,
    parameter int unsigned MAX_RETRIES          = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic [1:0] err_code
);

    // The start bit is asserted on the last inhibit cycle, so clk is held low
    // for exactly INHIBIT_CYCLES cycles with data already low when it is released.
    localparam logic [19:0] INHIBIT_LAST  = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] INHIBIT_START = 20'(INHIBIT_CYCLES - 2);
    localparam logic [19:0] START_LIMIT   = 20'(START_TIMEOUT_CYCLES - 1);
    localparam logic [19:0] XFER_LIMIT    = 20'(XFER_TIMEOUT_CYCLES - 1);
    localparam logic [19:0] TIMER_MAX     = 20'hFFFFF;
    // Index of the stop bit among the ten shifted bits
    localparam logic [3:0]  LAST_BIT      = 4'(FRAME_BITS - 2);

    logic [2:0]  state_r;
    logic [19:0] timer_r;
    logic [3:0]  bit_cnt_r;
    logic [9:0]  shift_r;
    logic        clk_oe_r;
    logic        data_oe_r;
    logic        done_r;
    logic        ack_ok_r;
    logic [1:0]  err_r;

    logic        clk_sync_s;
    logic        clk_rise_s;
    logic        clk_fall_s;
    logic        data_sync_s;
    logic        data_rise_unused_s;
    logic        data_fall_unused_s;

    logic        fail_s;
    logic [1:0]  fail_code_s;
    logic        retry_s;

    ps2_line_sync u_clk_sync (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2_clk_in),
        .line_sync (clk_sync_s),
        .rise      (clk_rise_s),
        .fall      (clk_fall_s)
    );

    ps2_line_sync u_data_sync (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2_data_in),
        .line_sync (data_sync_s),
        .rise      (data_rise_unused_s),
        .fall      (data_fall_unused_s)
    );

`ifdef PS2_TX_RETRY_EN
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);
    logic [1:0] retry_cnt_r;
    logic [7:0] byte_r;
    assign retry_s = (retry_cnt_r < RETRY_LIMIT);
`else
    logic [1:0] max_retries_unused_s;
    assign max_retries_unused_s = 2'(MAX_RETRIES);
    assign retry_s = 1'b0;
`endif

    // Failure detection for the current state; a NACK takes precedence over a timeout
    always_comb begin
        fail_s      = 1'b0;
        fail_code_s = ERR_NONE;
        case (state_r)
            ST_WAIT_FIRST: begin
                if (!clk_fall_s && (timer_r >= START_LIMIT)) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_START_TO;
                end else begin
                    fail_s      = 1'b0;
                    fail_code_s = ERR_NONE;
                end
            end
            ST_SHIFT, ST_RELEASE: begin
                if (timer_r >= XFER_LIMIT) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_XFER_TO;
                end else begin
                    fail_s      = 1'b0;
                    fail_code_s = ERR_NONE;
                end
            end
            ST_ACK: begin
                if (clk_rise_s && data_sync_s) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_NACK;
                end else if (timer_r >= XFER_LIMIT) begin
                    fail_s      = 1'b1;
                    fail_code_s = ERR_XFER_TO;
                end else begin
                    fail_s      = 1'b0;
                    fail_code_s = ERR_NONE;
                end
            end
            default: begin
                fail_s      = 1'b0;
                fail_code_s = ERR_NONE;
            end
        endcase
    end

    // Main sequencer: state, saturating timer, shift register and registered line/result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            timer_r     <= 20'd0;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 10'd0;
            clk_oe_r    <= 1'b0;
            data_oe_r   <= 1'b0;
            done_r      <= 1'b0;
            ack_ok_r    <= 1'b0;
            err_r       <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
            retry_cnt_r <= 2'd0;
            byte_r      <= 8'd0;
`endif
        end else begin
            done_r  <= 1'b0;
            timer_r <= (timer_r == TIMER_MAX) ? timer_r : (timer_r + 20'd1);
            if (fail_s) begin
                if (retry_s) begin
                    // Start the whole frame over from the inhibit phase
                    state_r     <= ST_INHIBIT;
                    timer_r     <= 20'd0;
                    bit_cnt_r   <= 4'd0;
                    clk_oe_r    <= 1'b1;
                    data_oe_r   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                    shift_r     <= build_frame(byte_r);
                    retry_cnt_r <= retry_cnt_r + 2'd1;
`endif
                end else begin
                    state_r   <= ST_FAIL;
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    done_r    <= 1'b1;
                    ack_ok_r  <= 1'b0;
                    err_r     <= fail_code_s;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (tx_valid) begin
                            state_r     <= ST_INHIBIT;
                            timer_r     <= 20'd0;
                            bit_cnt_r   <= 4'd0;
                            shift_r     <= build_frame(tx_data);
                            clk_oe_r    <= 1'b1;
                            data_oe_r   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                            byte_r      <= tx_data;
                            retry_cnt_r <= 2'd0;
`endif
                        end
                    end
                    ST_INHIBIT: begin
                        if (timer_r == INHIBIT_LAST) begin
                            clk_oe_r <= 1'b0;
                            state_r  <= ST_WAIT_FIRST;
                            timer_r  <= 20'd0;
                        end else if (timer_r == INHIBIT_START) begin
                            data_oe_r <= 1'b1;
                        end
                    end
                    ST_WAIT_FIRST: begin
                        if (clk_fall_s) begin
                            state_r   <= ST_SHIFT;
                            timer_r   <= 20'd0;
                            bit_cnt_r <= 4'd0;
                            data_oe_r <= ~shift_r[0];
                            shift_r   <= {1'b1, shift_r[9:1]};
                        end
                    end
                    ST_SHIFT: begin
                        if (clk_fall_s) begin
                            if (bit_cnt_r == LAST_BIT) begin
                                state_r <= ST_ACK;
                            end else begin
                                data_oe_r <= ~shift_r[0];
                                shift_r   <= {1'b1, shift_r[9:1]};
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_ACK: begin
                        // A high data level at this rise is caught as NACK by the failure logic
                        if (clk_rise_s) begin
                            state_r <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (clk_sync_s && data_sync_s) begin
                            state_r  <= ST_IDLE;
                            done_r   <= 1'b1;
                            ack_ok_r <= 1'b1;
                            err_r    <= ERR_NONE;
                        end
                    end
                    ST_FAIL: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        clk_oe_r  <= 1'b0;
                        data_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;
    assign done        = done_r;
    assign ack_ok      = ack_ok_r;
    assign err_code    = err_r;

endmodule

// File: doc/ps2_transmitter.md
Name: ps2_transmitter

Overview:
- Host-to-device PS/2 sender. Sends one command byte (LED set 0xED, reset 0xFF, enable 0xF4, resend 0xFE, ...) from the system to the keyboard.
- Drives the open-drain ps2_clk/ps2_data lines through output-enable pins; the pad logic pulls a line low when its enable is 1.
- Sits beside the keyboard receiver on the same two wires and uses the system clock domain.
- Reports completion, device ACK, or error to the command sequencer.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles that ps2_clk is held low before the start bit (100 us at 50 MHz).
- START_TIMEOUT_CYCLES, 750000, max cycles from clock release to the first device falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, 100000, max cycles from the first falling edge to ACK (2 ms).
- MAX_RETRIES, 2, automatic retries; used only with PS2_TX_RETRY_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted when tx_valid and tx_ready are both high.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS/2 clock line.
- ps2_data_in  in  1  raw PS/2 data line.
- ps2_clk_oe  out  1  1 = pull ps2_clk low.
- ps2_data_oe  out  1  1 = pull ps2_data low.
- busy  out  1  high in any state except IDLE.
- done  out  1  1-cycle pulse at the end of a transfer.
- ack_ok  out  1  valid with done: 1 = device ACK received.
- err_code  out  2  valid with done: 00 none, 01 NACK, 10 start timeout, 11 transfer timeout.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; ps2_clk_oe=0 and ps2_data_oe=0 immediately, so both lines are released.
  - done=0, ack_ok=0, err_code=00, busy=0, tx_ready=1.
  - Shift register, bit counter and timer cleared.
  - Reset mid-transfer simply abandons the frame.
- Line inputs:
  - ps2_clk_in and ps2_data_in pass through a 2-flop synchronizer.
  - Falling/rising edge pulses come from a 3rd register, giving 3 cycles of latency from pin to edge pulse.
- Frame: 11 bits, sent in this order:
  - start bit 0
  - data[0] to data[7], LSB first
  - odd parity (parity = ~^tx_data)
  - stop bit 1
  - device ACK, sampled as data low.
- Handshake: on accept, tx_data is latched into a 10-bit shift register {stop, parity, data}. tx_ready drops on the next cycle. tx_valid while busy is ignored.
- FSM states:
  - IDLE: on accept -> INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0. Timer counts INHIBIT_CYCLES.
    - At terminal count: data_oe=1 (start bit); hold 1 more cycle, then clk_oe=0 -> WAIT_FIRST.
  - WAIT_FIRST: data_oe stays 1. On the first falling edge -> SHIFT with bit count=0, and drive bit 0.
    - Timer reaching START_TIMEOUT_CYCLES -> FAIL with err 10.
  - SHIFT: the bit is driven right after each falling edge: data_oe = ~current bit. Device samples on the rising edge. Each falling edge advances the count.
    - After the stop bit has been driven (data_oe=0), the next falling edge -> ACK.
  - ACK: on the rising edge following that falling edge, sample synchronized data: 0 = ACK, 1 = NACK.
    - ACK -> RELEASE.
    - NACK -> FAIL with err 01.
  - RELEASE: wait until both synchronized lines are high, then emit done with ack_ok=1 -> IDLE.
  - FAIL: release both lines. done=1, ack_ok=0, err_code set for 1 cycle -> IDLE.
- Transfer timeout: the timer restarts at the first falling edge. Reaching XFER_TIMEOUT_CYCLES in SHIFT, ACK or RELEASE -> FAIL with err 11.
- Timer is 20 bits and saturates; it never wraps.
- A device frame in progress at accept is overridden by the inhibit; discarding the partial frame is the receiver's job.
- ack_ok and err_code hold their value until the next done.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - NACK or either timeout restarts at INHIBIT with the latched byte, up to MAX_RETRIES times.
  - done is raised only on success or after the final failure; err_code is the last failure's code.
  - A 2-bit retry counter is cleared on accept.
- Undefined: the first failure ends the transfer; MAX_RETRIES is unused.

Decomposition:
- Package ps2_pkg:
  - FSM state enum.
  - err_code constants: ERR_NONE, ERR_NACK, ERR_START_TO, ERR_XFER_TO.
  - Command constants: CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESEND=8'hFE, CMD_RESET=8'hFF.
  - Frame length constant 11.
- Sub-module ps2_line_sync: 2-flop synchronizer plus rise/fall edge detect for one line. Two instances; reusable by the receiver.

Test Plan:
- Send 0xED, device model ACKs:
  - ps2_clk_oe low for exactly 5000 cycles; start bit 0.
  - Device captures data bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
  - done with ack_ok=1, err_code=00.
- Send 0xF4 with NACK (data high at ACK): parity bit captured 0; done, ack_ok=0, err_code=01.
- Device never clocks after 0xFF: done with err_code=10 exactly 750000 cycles after clk release; both oe low.
- Device stops clocking after 4 edges of 0x00: err_code=11 at 100000 cycles after the first edge.
- Assert rst mid-SHIFT: both oe=0 with no clock edge; then a new 0x01 transfer succeeds with parity 0.
- PS2_TX_RETRY_EN: two NACKs then an ACK gives exactly 3 inhibit pulses and one done with ack_ok=1. Three NACKs give a single done with err_code=01.
